// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// 32 shift-add or restoring-divide steps, then one sign-fix cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hilo_rd,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int W = XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   opr_q;
  logic [W-1:0]   a_q;
  logic           is_div_q;
  logic           div0_q;
  logic           neg_q_q;
  logic           neg_r_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           busy_q;
  logic           done_q;

  logic           sgn_op;
  logic           div_op;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;

  always_comb begin
    sgn_op = ~op[0];
    div_op = op[1];
    abs_a  = (sgn_op && a[W-1]) ? (~a + 1'b1) : a;
    abs_b  = (sgn_op && b[W-1]) ? (~b + 1'b1) : b;
  end

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;
  logic [W:0]     div_sh;
  logic [W:0]     div_tr;
  logic [2*W-1:0] div_nxt;

  // Multiply keeps the carry of each add in mul_sum before the shift.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]}
            + (acc_q[0] ? {1'b0, opr_q} : '0);
    mul_nxt = {mul_sum, acc_q[W-1:1]};
    div_sh  = acc_q[2*W-1:W-1];
    div_tr  = div_sh - {1'b0, opr_q};
    if (div_tr[W]) begin
      div_nxt = {div_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_nxt = {div_tr[W-1:0], acc_q[W-2:0], 1'b1};
    end
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  always_comb begin
    prod = neg_q_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem  = neg_r_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    if (div0_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = rem;
      fix_lo = quot;
    end else begin
      fix_hi = prod[2*W-1:W];
      fix_lo = prod[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!flush) begin
            if (start) begin
              state_q  <= CALC;
              busy_q   <= 1'b1;
              cnt_q    <= 5'd31;
              a_q      <= a;
              is_div_q <= div_op;
              div0_q   <= div_op && (b == '0);
              neg_q_q  <= sgn_op && (a[W-1] ^ b[W-1]);
              neg_r_q  <= sgn_op && a[W-1];
              // Divide iterates on the dividend; multiply on the multiplier.
              opr_q    <= div_op ? abs_b : abs_a;
              acc_q    <= {{W{1'b0}}, div_op ? abs_a : abs_b};
            end
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= is_div_q ? div_nxt : mul_nxt;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (start | hilo_rd | mthi | mtlo);

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the MIPS pipeline's EX stage. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over 33 cycles: one bit per cycle of shift-add multiply or restoring divide, then a sign-fix cycle. It drives a stall request so the hazard logic holds the pipeline while a HI/LO consumer or a new mul/div op would collide with a running operation. It also handles MTHI/MTLO writes and is cancelled by pipeline flush.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX stage holds a mul/div instruction
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  XLEN  rs operand (multiplicand/dividend)
- b  in  XLEN  rt operand (multiplier/divisor)
- flush  in  1  cancel the in-flight operation
- hilo_rd  in  1  EX stage holds MFHI/MFLO
- mthi, mtlo  in  1  EX stage holds MTHI/MTLO
- wdata  in  XLEN  data for MTHI/MTLO
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on result write
- stall  out  1  combinational: busy & (start | hilo_rd | mthi | mtlo)
- hi, lo  out  XLEN  architectural HI/LO registers

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on start & !flush, latch the operands and go to CALC.
  - Signed ops latch |a| and |b| and record neg_q = a[31]^b[31] and neg_r = a[31].
  - Unsigned ops latch the operands raw, with neg_q = neg_r = 0.
  - Record div0 = (b == 0) for DIV/DIVU.
  - Load cnt = 31.
- CALC: one iteration per cycle; cnt decrements and the state moves to FIX after the cnt == 0 iteration, which makes 32 iterations.
  - Multiply: 64-bit shift-add on a 65-bit accumulator.
  - Divide: restoring. Shift {rem, quot} left, trial-subtract the divisor, keep the result when it is non-negative and set quot bit 0.
- FIX: write HI/LO, pulse done, return to IDLE.
  - Multiply: product negated (64-bit two's complement) if neg_q; HI = [63:32], LO = [31:0].
  - Divide: LO = quot, negated if neg_q; HI = rem, negated if neg_r.
  - div0: LO = 32'hFFFFFFFF and HI = the original a, with no sign fix.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0. This is the natural result of the magnitude path; no special case is needed.
- MTHI/MTLO: write hi/lo from wdata at the edge, only in IDLE with !flush. MTHI and MTLO in the same cycle write both registers.
- Any request while busy (start, hilo_rd, mthi, mtlo) is not acted on; stall stays high until busy falls.
  - The pipeline is frozen, so the request is re-presented and accepted in the first IDLE cycle.
- flush: from CALC or FIX, go to IDLE at the next edge. HI/LO are unchanged, done is not asserted, and busy = 0 after that edge. In IDLE, flush suppresses start and mthi/mtlo.
- Simultaneous start and flush in IDLE: flush wins, nothing is started.

## Timing
- Reset (async, immediate): state IDLE, hi = lo = 0, busy = 0, done = 0, cnt = 0; datapath registers cleared.
- Reset mid-operation: returns to the reset values above. The result is discarded and HI/LO are forced to 0.
- busy = (state != IDLE), registered. It rises after the start edge E0 and falls after edge E33.
- HI/LO are updated at E33. done is high for the single cycle following E33, together with busy = 0.
- Total latency is 33 edges: start sampled at E0, result visible in the cycle after E33. It is identical for all ops, including div0.
- Back-to-back: a start in the done cycle is accepted (state is IDLE).
- MTHI/MTLO latency is 1 edge.
- hi/lo are plain register outputs; there is no bypass of a same-cycle write.

## Test plan
- MULT a = -3 (0xFFFFFFFD), b = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - busy for exactly 33 cycles; done pulses once in the cycle after E33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
  - Then a back-to-back start in the done cycle: MULTU 2 × 3 -> HI = 0, LO = 6.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 3 -> LO = 33, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100; latency still 33.
- MTHI 0x12345678 in IDLE -> hi = 0x12345678 next cycle.
- Start MULT 5 × 5, then assert flush 10 cycles after E0:
  - busy = 0 after the next edge, HI/LO keep their old values, no done pulse.
  - A new MULT 5 × 5 afterwards gives LO = 25.
- During busy, assert hilo_rd, mtlo and start in turn -> stall = 1 each cycle.
  - HI/LO are not written by the mtlo while busy.
  - stall drops in the done cycle.
- Assert rst_n = 0 mid-CALC -> busy, done, hi and lo go to 0 immediately.
